// File: rtl/bus_decoder_ws.sv
// rtl/bus_decoder_ws.sv - JB-8 bus decoder with per-region wait states and ROM bank register
// Optional bus error pulse built when DECODER_BUSERR_EN is defined.
module bus_decoder_ws #(
    parameter int          IO_CHANNELS    = 4,
    parameter logic [15:0] IO_BASE        = 16'hE000,
    parameter int          IO_STRIDE_LOG2 = 4,
    parameter logic [15:0] ROM_BASE       = 16'hE100,
    parameter int          BANK_BITS      = 3,
    parameter int          RAM_WAIT       = 0,
    parameter int          IO_WAIT        = 2,
    parameter int          ROM_WAIT       = 1
) (
    input  logic                   clk,
    input  logic                   rst_N,
    input  logic [15:0]            addr,
    input  logic                   bus_e,
    input  logic                   bus_rw,
    input  logic [7:0]             data_in,
    output logic                   ram_sel_N,
    output logic                   rom_sel_N,
    output logic [IO_CHANNELS-1:0] io_sel_N,
    output logic                   rd_N,
    output logic                   wr_N,
    output logic                   mrdy,
    output logic [BANK_BITS-1:0]   rom_bank,
    output logic                   bus_err
);

    localparam int          STRIDE   = 1 << IO_STRIDE_LOG2;
    localparam logic [16:0] BREG_LO  = {1'b0, IO_BASE} + 17'(IO_CHANNELS * STRIDE);
    localparam logic [16:0] BREG_HI  = BREG_LO + 17'(STRIDE);
    localparam logic [3:0]  RAM_W    = 4'(RAM_WAIT);
    localparam logic [3:0]  IO_W     = 4'(IO_WAIT);
    localparam logic [3:0]  ROM_W    = 4'(ROM_WAIT);

    generate
        if (BREG_HI > {1'b0, ROM_BASE}) begin : g_bad_map
            $error("bus_decoder_ws: bank register slot overlaps ROM_BASE");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_e_q;
    logic [BANK_BITS-1:0]   r_rom_bank;

    logic [16:0]            w_addr_x;
    logic                   w_ram;
    logic                   w_rom;
    logic                   w_breg;
    logic [IO_CHANNELS-1:0] w_io;
    logic                   w_io_any;
    logic                   w_rise;
    logic                   w_fall;
    logic [3:0]             w_wait;
    logic                   w_unused;

    assign w_addr_x = {1'b0, addr};
    assign w_ram    = addr < IO_BASE;
    assign w_rom    = addr >= ROM_BASE;
    assign w_breg   = (w_addr_x >= BREG_LO) && (w_addr_x < BREG_HI);

    genvar k;
    generate
        for (k = 0; k < IO_CHANNELS; k++) begin : g_io
            localparam logic [16:0] SLOT_LO = {1'b0, IO_BASE} + 17'(k * STRIDE);
            localparam logic [16:0] SLOT_HI = SLOT_LO + 17'(STRIDE);
            assign w_io[k] = (w_addr_x >= SLOT_LO) && (w_addr_x < SLOT_HI);
        end
    endgenerate

    assign w_io_any  = |w_io;
    assign ram_sel_N = ~w_ram;
    assign rom_sel_N = ~w_rom;
    assign io_sel_N  = ~w_io;
    assign rd_N      = ~(bus_e & bus_rw);
    assign wr_N      = ~(bus_e & ~bus_rw);

    assign w_rise = bus_e & ~r_e_q;
    assign w_fall = ~bus_e & r_e_q;

    // Bank register slot and reserved hole both run with no wait states.
    always_comb begin
        w_wait = 4'd0;
        if (w_ram)
            w_wait = RAM_W;
        else if (w_io_any)
            w_wait = IO_W;
        else if (w_rom)
            w_wait = ROM_W;
    end

    assign mrdy = ~(((r_state == S_IDLE) && w_rise && (w_wait != 4'd0)) ||
                    ((r_state == S_WAIT) && !w_fall));

    // The rise cycle is the first wait clk, so cnt holds the remaining ones.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_e_q      <= 1'b0;
            r_rom_bank <= '0;
        end else begin
            r_e_q <= bus_e;
            if (w_fall && !bus_rw && w_breg)
                r_rom_bank <= data_in[BANK_BITS-1:0];
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        if (w_wait > 4'd1) begin
                            r_cnt   <= w_wait - 4'd1;
                            r_state <= S_WAIT;
                        end else begin
                            r_cnt   <= 4'd0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_fall) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_fall)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_bank = r_rom_bank;
    assign w_unused = &{1'b0, data_in, r_cnt};

`ifdef DECODER_BUSERR_EN
    logic w_hole;
    logic r_bus_err;

    assign w_hole = ~w_ram & ~w_io_any & ~w_breg & ~w_rom;

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N)
            r_bus_err <= 1'b0;
        else
            r_bus_err <= w_fall & (w_hole | (w_rom & ~bus_rw) | (w_breg & bus_rw));
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_decoder_ws.sv
// tb/tb_bus_decoder_ws.sv - directed self-checking bench for bus_decoder_ws
module tb_bus_decoder_ws;

    logic        clk;
    logic        rst_N;
    logic [15:0] addr;
    logic        bus_e;
    logic        bus_rw;
    logic [7:0]  data_in;
    logic        ram_sel_N;
    logic        rom_sel_N;
    logic [3:0]  io_sel_N;
    logic        rd_N;
    logic        wr_N;
    logic        mrdy;
    logic [2:0]  rom_bank;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DECODER_BUSERR_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    bus_decoder_ws dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .addr      (addr),
        .bus_e     (bus_e),
        .bus_rw    (bus_rw),
        .data_in   (data_in),
        .ram_sel_N (ram_sel_N),
        .rom_sel_N (rom_sel_N),
        .io_sel_N  (io_sel_N),
        .rd_N      (rd_N),
        .wr_N      (wr_N),
        .mrdy      (mrdy),
        .rom_bank  (rom_bank),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selects only, bus idle.
    task automatic decode(input string tag, input logic [15:0] a, input logic [6:0] exp_sel);
        addr = a;
        #1;
        check(tag, {25'd0, ram_sel_N, rom_sel_N, io_sel_N, rd_N}, {25'd0, exp_sel});
    endtask

    // One E-high access of hi clks; records mrdy per clk, strobes, fall-cycle mrdy and bus_err pulses.
    task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] d, input int hi,
                          output logic [15:0] pat, output logic rd0, output logic wr0,
                          output logic fall_rdy, output int errs);
        addr    = a;
        bus_rw  = rw;
        data_in = d;
        bus_e   = 1'b1;
        pat     = 16'hFFFF;
        rd0     = 1'b1;
        wr0     = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            pat[i] = mrdy;
            if (i == 0) begin
                rd0 = rd_N;
                wr0 = wr_N;
            end
            step();
        end
        bus_e    = 1'b0;
        errs     = 0;
        fall_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) fall_rdy = mrdy;
            if (bus_err) errs++;
            step();
        end
        addr   = 16'hE050;
        bus_rw = 1'b1;
    endtask

    logic [15:0] pat;
    logic        rd0, wr0, frdy;
    int          errs;

    initial begin
        rst_N   = 1'b0;
        addr    = 16'hE050;
        bus_e   = 1'b0;
        bus_rw  = 1'b1;
        data_in = 8'h00;
        repeat (3) step();
        rst_N = 1'b1;
        step();

        @(negedge clk);
        check("reset_sel", {ram_sel_N, rom_sel_N, io_sel_N}, 6'b111111);
        check("reset_mrdy", mrdy, 1'b1);
        check("reset_bank", rom_bank, 3'd0);
        check("reset_err", bus_err, 1'b0);
        check("reset_strobes", {rd_N, wr_N}, 2'b11);
        step();

        decode("dec_ram_edge", 16'hDFFF, 7'b0111111);
        decode("dec_io0_lo", 16'hE000, 7'b1111101);
        decode("dec_io3_hi", 16'hE03F, 7'b1101111);
        decode("dec_breg", 16'hE040, 7'b1111111);
        decode("dec_hole", 16'hE0FF, 7'b1111111);
        decode("dec_rom_edge", 16'hE100, 7'b1011111);
        decode("dec_io2", 16'hE025, 7'b1110111);

        access(16'h1234, 1'b1, 8'h00, 8, pat, rd0, wr0, frdy, errs);
        check("ram_mrdy", pat, 16'hFFFF);
        check("ram_strobes", {rd0, wr0}, 2'b01);
        check("ram_err", errs, 0);

        access(16'hE025, 1'b1, 8'h00, 8, pat, rd0, wr0, frdy, errs);
        check("io_mrdy", pat, 16'hFFFC);
        check("io_fall_mrdy", frdy, 1'b1);

        access(16'hE040, 1'b0, 8'hF5, 4, pat, rd0, wr0, frdy, errs);
        check("breg_mrdy", pat, 16'hFFFF);
        check("breg_strobes", {rd0, wr0}, 2'b10);
        check("breg_bank", rom_bank, 3'b101);
        check("breg_wr_err", errs, 0);

        addr = 16'hF000;
        #1;
        check("rom_sel", {ram_sel_N, rom_sel_N, io_sel_N}, 6'b101111);
        access(16'hF000, 1'b1, 8'h00, 6, pat, rd0, wr0, frdy, errs);
        check("rom_mrdy", pat, 16'hFFFE);
        check("rom_rd_err", errs, 0);

        access(16'hE025, 1'b1, 8'h00, 1, pat, rd0, wr0, frdy, errs);
        check("timeout_mrdy", pat, 16'hFFFE);
        check("timeout_fall_mrdy", frdy, 1'b1);
        access(16'hE025, 1'b1, 8'h00, 5, pat, rd0, wr0, frdy, errs);
        check("after_timeout_mrdy", pat, 16'hFFFC);

        addr   = 16'hE025;
        bus_rw = 1'b1;
        bus_e  = 1'b1;
        @(negedge clk);
        check("rst_wait0", mrdy, 1'b0);
        step();
        @(negedge clk);
        check("rst_wait1", mrdy, 1'b0);
        rst_N = 1'b0;
        bus_e = 1'b0;
        #1;
        check("rst_mid_mrdy", mrdy, 1'b1);
        check("rst_mid_bank", rom_bank, 3'd0);
        step();
        rst_N = 1'b1;
        step();
        access(16'hE025, 1'b1, 8'h00, 6, pat, rd0, wr0, frdy, errs);
        check("post_rst_mrdy", pat, 16'hFFFC);

        access(16'hE080, 1'b0, 8'h00, 3, pat, rd0, wr0, frdy, errs);
        check("err_hole_wr", errs, ERR_EXP);
        access(16'hF000, 1'b0, 8'h00, 3, pat, rd0, wr0, frdy, errs);
        check("err_rom_wr", errs, ERR_EXP);
        check("rom_wr_mrdy", pat, 16'hFFFE);
        access(16'hE040, 1'b1, 8'h00, 3, pat, rd0, wr0, frdy, errs);
        check("err_breg_rd", errs, ERR_EXP);
        check("breg_rd_bank", rom_bank, 3'd0);
        access(16'h0100, 1'b0, 8'h00, 3, pat, rd0, wr0, frdy, errs);
        check("err_ram_wr", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary, expected completion");
        $fatal(1);
    end

endmodule
